ibex_fcsr_wr_ctrl: RTL and testbench

// - Write-side controller for the 8-bit floating-point CSR (fcsr = {frm[2:0], fflags[4:0]}); feeds wr_data/wr_en of the fcsr storage register.
// - Performs sticky accumulation of FPU exception flags.
// - Performs read-modify-write for CSR instructions (write/set/clear/read) on fflags, frm and fcsr.
// - Monitors the shadow-copy integrity error of the fcsr storage register.

---
 rtl/ibex_fcsr_wr_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ibex_fcsr_wr_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fcsr_wr_ctrl.sv
// ibex_fcsr_wr_ctrl
//   Write-side controller for the 8-bit fcsr = {frm[2:0], fflags[4:0]}.
//   Accumulates sticky FPU exception flags in pending_q and flushes them into
//   the fcsr storage register. Executes CSR read/write/set/clear on fflags,
//   frm or the whole fcsr. Watches the storage shadow-mismatch signal and
//   locks up in ERR until reset.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   fpu_valid_i/fpu_flags_i/fpu_ready_o  retiring FPU flags handshake
//   csr_op_valid_i/csr_op_ready_o     CSR request handshake
//   csr_op_i   00 READ 01 WRITE 10 SET 11 CLEAR
//   csr_sel_i  01 fflags 10 frm 11 fcsr 00 illegal
//   csr_wdata_i                       operand
//   csr_rvalid_o/csr_rdata_o/csr_illegal_o  one-cycle completion
//   fcsr_rd_data_i/fcsr_rd_error_i    storage read value / shadow mismatch
//   fcsr_wr_data_o/fcsr_wr_en_o       storage write port
//   err_o                             sticky integrity error
//   flag_cnt_o                        (IBEX_FCSR_FLAG_CNT_EN only) count of
//                                     accepted FPU ops carrying flags
//
// Configuration macro: IBEX_FCSR_FLAG_CNT_EN
module ibex_fcsr_wr_ctrl #(
  parameter int unsigned FlagWidth = 5,
  parameter int unsigned FrmWidth  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          fpu_valid_i,
  input  logic [FlagWidth-1:0]          fpu_flags_i,
  output logic                          fpu_ready_o,
  input  logic                          csr_op_valid_i,
  output logic                          csr_op_ready_o,
  input  logic [1:0]                    csr_op_i,
  input  logic [1:0]                    csr_sel_i,
  input  logic [FlagWidth+FrmWidth-1:0] csr_wdata_i,
  output logic                          csr_rvalid_o,
  output logic [FlagWidth+FrmWidth-1:0] csr_rdata_o,
  output logic                          csr_illegal_o,
  input  logic [FlagWidth+FrmWidth-1:0] fcsr_rd_data_i,
  input  logic                          fcsr_rd_error_i,
  output logic [FlagWidth+FrmWidth-1:0] fcsr_wr_data_o,
  output logic                          fcsr_wr_en_o,
`ifdef IBEX_FCSR_FLAG_CNT_EN
  output logic [15:0]                   flag_cnt_o,
`endif
  output logic                          err_o
);

  localparam int unsigned CsrW = FlagWidth + FrmWidth;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, ERR = 2'd2} state_e;

  state_e               state_q;
  logic [FlagWidth-1:0] pending_q;
  logic [1:0]           op_q, sel_q;
  logic [CsrW-1:0]      wdata_q;

  logic                 fpu_acc, op_acc, pend_nz, sel_legal, csr_wr, flush;
  logic [FlagWidth-1:0] acc_flags;
  logic [CsrW-1:0]      old_val, new_val, fld_mask, fld_bits, fld_rd, wr_val;

  assign fpu_ready_o    = (state_q != ERR);
  assign csr_op_ready_o = (state_q == IDLE);
  assign err_o          = (state_q == ERR);

  assign fpu_acc   = fpu_valid_i & fpu_ready_o;
  assign op_acc    = csr_op_valid_i & csr_op_ready_o;
  assign acc_flags = fpu_acc ? fpu_flags_i : '0;
  assign pend_nz   = |pending_q;

  // Architectural value: storage plus flags not yet written back.
  assign old_val   = fcsr_rd_data_i | {{FrmWidth{1'b0}}, pending_q};
  assign sel_legal = (sel_q != 2'b00);

  always_comb begin
    fld_mask = '0;
    fld_bits = '0;
    fld_rd   = '0;
    case (sel_q)
      2'b01: begin
        fld_mask = {{FrmWidth{1'b0}}, {FlagWidth{1'b1}}};
        fld_bits = {{FrmWidth{1'b0}}, wdata_q[FlagWidth-1:0]};
        fld_rd   = {{FrmWidth{1'b0}}, old_val[FlagWidth-1:0]};
      end
      2'b10: begin
        fld_mask = {{FrmWidth{1'b1}}, {FlagWidth{1'b0}}};
        fld_bits = {wdata_q[FrmWidth-1:0], {FlagWidth{1'b0}}};
        fld_rd   = {{FlagWidth{1'b0}}, old_val[CsrW-1:FlagWidth]};
      end
      2'b11: begin
        fld_mask = '1;
        fld_bits = wdata_q;
        fld_rd   = old_val;
      end
      default: ;
    endcase
  end

  // fld_bits is already confined to the selected field, so SET/CLEAR
  // leave the other field untouched without further masking.
  always_comb begin
    case (op_q)
      2'b01:   new_val = (old_val & ~fld_mask) | fld_bits;
      2'b10:   new_val = old_val | fld_bits;
      2'b11:   new_val = old_val & ~fld_bits;
      default: new_val = old_val;
    endcase
  end

  assign csr_wr = sel_legal & (op_q != 2'b00);

  // Accepting an op suppresses the idle flush: the flags stay in pending_q
  // and are folded into old_val during EXEC instead.
  assign flush = (state_q == IDLE) & ~op_acc & pend_nz;

  // Reset in the same cycle squashes any write or completion in flight.
  assign fcsr_wr_en_o   = ~rst_i & ~fcsr_rd_error_i &
                          (flush | ((state_q == EXEC) & (csr_wr | pend_nz)));
  assign wr_val         = ((state_q == EXEC) & csr_wr) ? new_val : old_val;
  assign fcsr_wr_data_o = fcsr_wr_en_o ? wr_val : '0;

  // An integrity error during EXEC still completes the op, flagged illegal.
  assign csr_rvalid_o  = (state_q == EXEC) & ~rst_i;
  assign csr_illegal_o = csr_rvalid_o & (~sel_legal | fcsr_rd_error_i);
  assign csr_rdata_o   = (csr_rvalid_o & ~csr_illegal_o) ? fld_rd : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      op_q      <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
    end else begin
      if (state_q != ERR) begin
        // A write consumes pending_q; flags accepted this cycle always survive.
        pending_q <= fcsr_wr_en_o ? acc_flags : (pending_q | acc_flags);
      end
      case (state_q)
        IDLE: begin
          if (op_acc) begin
            op_q    <= csr_op_i;
            sel_q   <= csr_sel_i;
            wdata_q <= csr_wdata_i;
          end
          if (fcsr_rd_error_i) state_q <= ERR;
          else if (op_acc)     state_q <= EXEC;
        end
        EXEC:    state_q <= fcsr_rd_error_i ? ERR : IDLE;
        default: state_q <= ERR;
      endcase
    end
  end

`ifdef IBEX_FCSR_FLAG_CNT_EN
  logic [15:0] flag_cnt_q;

  // fpu_acc is low in ERR, which freezes the count there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flag_cnt_q <= '0;
    end else if (fpu_acc && (|fpu_flags_i) && (flag_cnt_q != 16'hFFFF)) begin
      flag_cnt_q <= flag_cnt_q + 16'd1;
    end
  end

  assign flag_cnt_o = flag_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_fcsr_wr_ctrl.sv
module tb_ibex_fcsr_wr_ctrl;
  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       fpu_valid_i = 1'b0;
  logic [4:0] fpu_flags_i = '0;
  logic       fpu_ready_o;
  logic       csr_op_valid_i = 1'b0;
  logic       csr_op_ready_o;
  logic [1:0] csr_op_i = '0;
  logic [1:0] csr_sel_i = '0;
  logic [7:0] csr_wdata_i = '0;
  logic       csr_rvalid_o;
  logic [7:0] csr_rdata_o;
  logic       csr_illegal_o;
  logic [7:0] fcsr_store;
  logic       fcsr_rd_error_i = 1'b0;
  logic [7:0] fcsr_wr_data_o;
  logic       fcsr_wr_en_o;
  logic       err_o;
`ifdef IBEX_FCSR_FLAG_CNT_EN
  logic [15:0] flag_cnt_o;
`endif

  logic       preload_en = 1'b0;
  logic [7:0] preload_val = '0;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  // fcsr storage register the controller writes into.
  always @(posedge clk) begin
    if (preload_en)        fcsr_store <= preload_val;
    else if (fcsr_wr_en_o) fcsr_store <= fcsr_wr_data_o;
  end

  ibex_fcsr_wr_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .fpu_valid_i(fpu_valid_i), .fpu_flags_i(fpu_flags_i), .fpu_ready_o(fpu_ready_o),
    .csr_op_valid_i(csr_op_valid_i), .csr_op_ready_o(csr_op_ready_o),
    .csr_op_i(csr_op_i), .csr_sel_i(csr_sel_i), .csr_wdata_i(csr_wdata_i),
    .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .fcsr_rd_data_i(fcsr_store), .fcsr_rd_error_i(fcsr_rd_error_i),
    .fcsr_wr_data_o(fcsr_wr_data_o), .fcsr_wr_en_o(fcsr_wr_en_o),
`ifdef IBEX_FCSR_FLAG_CNT_EN
    .flag_cnt_o(flag_cnt_o),
`endif
    .err_o(err_o)
  );

  // Reference: CSR ops act on the named field(s) of the architectural fcsr.
  function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] cur,
                                          input logic [7:0] w);
    case (op)
      2'b01:   return w;
      2'b10:   return cur | w;
      2'b11:   return cur & ~w;
      default: return cur;
    endcase
  endfunction

  function automatic logic [7:0] ref_new(input logic [1:0] op, input logic [1:0] sel,
                                         input logic [7:0] wd, input logic [7:0] old);
    logic [7:0] fl, rm;
    fl = {3'b0, old[4:0]};
    rm = {5'b0, old[7:5]};
    if (sel == 2'b01 || sel == 2'b11) fl = apply_op(op, fl, {3'b0, wd[4:0]});
    if (sel == 2'b10) rm = apply_op(op, rm, {5'b0, wd[2:0]});
    if (sel == 2'b11) rm = apply_op(op, rm, {5'b0, wd[7:5]});
    return {rm[2:0], fl[4:0]};
  endfunction

  function automatic logic [7:0] ref_rd(input logic [1:0] sel, input logic [7:0] old);
    case (sel)
      2'b01:   return {3'b0, old[4:0]};
      2'b10:   return {5'b0, old[7:5]};
      2'b11:   return old;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    fpu_valid_i = 0; fpu_flags_i = '0; csr_op_valid_i = 0;
    csr_op_i = '0; csr_sel_i = '0; csr_wdata_i = '0; fcsr_rd_error_i = 0;
  endtask

  task automatic preload(input logic [7:0] v);
    preload_val = v; preload_en = 1; tick(); preload_en = 0;
  endtask

  task automatic do_reset();
    quiet(); rst_i = 1; tick(); tick(); rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (fpu_ready_o !== 1'b1) $display("FAIL rst_fpu_ready got %b exp 1", fpu_ready_o); else n_pass++;
    n_chk++; if (csr_op_ready_o !== 1'b1) $display("FAIL rst_op_ready got %b exp 1", csr_op_ready_o); else n_pass++;
    n_chk++; if ({csr_rvalid_o, csr_illegal_o, fcsr_wr_en_o, err_o} !== 4'b0)
      $display("FAIL rst_ctrl got %b exp 0000", {csr_rvalid_o, csr_illegal_o, fcsr_wr_en_o, err_o}); else n_pass++;
    n_chk++; if ({csr_rdata_o, fcsr_wr_data_o} !== 16'h0)
      $display("FAIL rst_data got %h exp 0000", {csr_rdata_o, fcsr_wr_data_o}); else n_pass++;
    preload(8'h00);
  endtask

  task automatic test_flag_example();
    fpu_valid_i = 1; fpu_flags_i = 5'b00001; #1;
    n_chk++; if (fcsr_wr_en_o !== 1'b0) $display("FAIL flg_first_wr got %b exp 0", fcsr_wr_en_o); else n_pass++;
    tick();
    fpu_flags_i = 5'b10000; #1;
    n_chk++; if ({fcsr_wr_en_o, fcsr_wr_data_o} !== {1'b1, 8'h01})
      $display("FAIL flg_wr1 got %b/%h exp 1/01", fcsr_wr_en_o, fcsr_wr_data_o); else n_pass++;
    tick();
    quiet(); #1;
    n_chk++; if ({fcsr_wr_en_o, fcsr_wr_data_o} !== {1'b1, 8'h11})
      $display("FAIL flg_wr2 got %b/%h exp 1/11", fcsr_wr_en_o, fcsr_wr_data_o); else n_pass++;
    tick(); #1;
    n_chk++; if (fcsr_store !== 8'h11) $display("FAIL flg_store got %h exp 11", fcsr_store); else n_pass++;
    n_chk++; if (fcsr_wr_en_o !== 1'b0) $display("FAIL flg_idle_wr got %b exp 0", fcsr_wr_en_o); else n_pass++;
  endtask

  task automatic test_flag_random();
    logic [7:0] s;
    logic [4:0] acc, f;
    logic       v;
    for (int r = 0; r < 3; r++) begin
      s = 8'($urandom); acc = '0;
      preload(s);
      for (int i = 0; i < 40; i++) begin
        v = 1'($urandom); f = 5'($urandom);
        fpu_valid_i = v; fpu_flags_i = f;
        if (v) acc = acc | f;
        #1;
        n_chk++; if (fpu_ready_o !== 1'b1) $display("FAIL rnd_fpu_ready got %b exp 1", fpu_ready_o); else n_pass++;
        tick();
      end
      quiet(); tick(); tick(); tick();
      n_chk++; if (fcsr_store !== (s | {3'b0, acc}))
        $display("FAIL rnd_sticky got %h exp %h", fcsr_store, s | {3'b0, acc}); else n_pass++;
    end
  endtask

  task automatic test_csr_ops();
    logic [7:0] s, wd, old, fin;
    logic [1:0] op, sel;
    logic [4:0] f0, f1, f2;
    logic       legal, exp_wr;
    for (int it = 0; it < 30; it++) begin
      if (it == 0) begin
        s = 8'hA3; op = 2'b10; sel = 2'b01; wd = 8'h08; f0 = 5'b00100; f1 = '0; f2 = '0;
      end else if (it == 1) begin
        s = 8'h5C; op = 2'b00; sel = 2'b00; wd = 8'h00; f0 = '0; f1 = '0; f2 = '0;
      end else if (it == 2) begin
        s = 8'hFF; op = 2'b01; sel = 2'b10; wd = 8'h02; f0 = '0; f1 = '0; f2 = 5'b00010;
      end else begin
        s = 8'($urandom); op = 2'($urandom); sel = 2'($urandom); wd = 8'($urandom);
        f0 = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom);
        f1 = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom);
        f2 = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom);
      end
      legal  = (sel != 2'b00);
      old    = s | {3'b0, f0 | f1};
      fin    = legal ? ref_new(op, sel, wd, old) : old;
      exp_wr = (legal && op != 2'b00) || ((f0 | f1) != 5'b0);
      preload(s);
      fpu_valid_i = 1; fpu_flags_i = f0; #1;
      n_chk++; if (fcsr_wr_en_o !== 1'b0) $display("FAIL op%0d_pre_wr got %b exp 0", it, fcsr_wr_en_o); else n_pass++;
      tick();
      fpu_flags_i = f1; csr_op_valid_i = 1; csr_op_i = op; csr_sel_i = sel; csr_wdata_i = wd; #1;
      n_chk++; if ({csr_op_ready_o, fcsr_wr_en_o} !== 2'b10)
        $display("FAIL op%0d_accept got rdy/wr %b exp 10", it, {csr_op_ready_o, fcsr_wr_en_o}); else n_pass++;
      tick();
      csr_op_valid_i = 0; csr_op_i = 2'($urandom); csr_sel_i = 2'($urandom); csr_wdata_i = 8'($urandom);
      fpu_flags_i = f2; #1;
      n_chk++; if ({csr_rvalid_o, csr_illegal_o, csr_op_ready_o} !== {1'b1, ~legal, 1'b0})
        $display("FAIL op%0d_done got %b exp %b", it, {csr_rvalid_o, csr_illegal_o, csr_op_ready_o}, {1'b1, ~legal, 1'b0}); else n_pass++;
      n_chk++; if (csr_rdata_o !== ref_rd(sel, old))
        $display("FAIL op%0d_rdata got %h exp %h", it, csr_rdata_o, ref_rd(sel, old)); else n_pass++;
      n_chk++; if (fcsr_wr_en_o !== exp_wr) $display("FAIL op%0d_wr_en got %b exp %b", it, fcsr_wr_en_o, exp_wr); else n_pass++;
      if (exp_wr) begin
        n_chk++; if (fcsr_wr_data_o !== fin) $display("FAIL op%0d_wr_data got %h exp %h", it, fcsr_wr_data_o, fin); else n_pass++;
      end
      tick();
      quiet(); #1;
      n_chk++; if (fcsr_wr_en_o !== (f2 != 5'b0))
        $display("FAIL op%0d_flush_en got %b exp %b", it, fcsr_wr_en_o, f2 != 5'b0); else n_pass++;
      if (f2 != 5'b0) begin
        n_chk++; if (fcsr_wr_data_o !== (fin | {3'b0, f2}))
          $display("FAIL op%0d_flush_data got %h exp %h", it, fcsr_wr_data_o, fin | {3'b0, f2}); else n_pass++;
      end
      tick(); tick();
      n_chk++; if (fcsr_store !== (fin | {3'b0, f2}))
        $display("FAIL op%0d_final got %h exp %h", it, fcsr_store, fin | {3'b0, f2}); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] arch, wd;
    logic [1:0] op, sel;
    arch = 8'($urandom);
    preload(arch);
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom); sel = 2'($urandom); wd = 8'($urandom);
      csr_op_valid_i = 1; csr_op_i = op; csr_sel_i = sel; csr_wdata_i = wd; #1;
      n_chk++; if (csr_op_ready_o !== 1'b1) $display("FAIL b2b%0d_ready got %b exp 1", i, csr_op_ready_o); else n_pass++;
      tick();
      n_chk++; if ({csr_rvalid_o, csr_op_ready_o, csr_rdata_o} !== {2'b10, ref_rd(sel, arch)})
        $display("FAIL b2b%0d_resp got %b%b/%h exp 10/%h", i, csr_rvalid_o, csr_op_ready_o, csr_rdata_o, ref_rd(sel, arch)); else n_pass++;
      if (sel != 2'b00) arch = ref_new(op, sel, wd, arch);
      tick();
    end
    quiet(); tick();
    n_chk++; if (fcsr_store !== arch) $display("FAIL b2b_final got %h exp %h", fcsr_store, arch); else n_pass++;
  endtask

  task automatic test_reset_midop();
    preload(8'h3C);
    csr_op_valid_i = 1; csr_op_i = 2'b01; csr_sel_i = 2'b11; csr_wdata_i = 8'hC3;
    tick();
    quiet(); rst_i = 1; #1;
    n_chk++; if ({csr_rvalid_o, fcsr_wr_en_o} !== 2'b00)
      $display("FAIL rstmid_squash got %b exp 00", {csr_rvalid_o, fcsr_wr_en_o}); else n_pass++;
    tick();
    rst_i = 0; #1;
    n_chk++; if ({csr_op_ready_o, csr_rvalid_o, fcsr_wr_en_o} !== 3'b100)
      $display("FAIL rstmid_idle got %b exp 100", {csr_op_ready_o, csr_rvalid_o, fcsr_wr_en_o}); else n_pass++;
    tick();
    n_chk++; if (fcsr_store !== 8'h3C) $display("FAIL rstmid_store got %h exp 3c", fcsr_store); else n_pass++;
  endtask

  task automatic test_integrity();
    // Error while an op executes.
    preload(8'h96);
    csr_op_valid_i = 1; csr_op_i = 2'b01; csr_sel_i = 2'b11; csr_wdata_i = 8'h55;
    tick();
    csr_op_valid_i = 0; fcsr_rd_error_i = 1; #1;
    n_chk++; if ({fcsr_wr_en_o, csr_rvalid_o, csr_illegal_o} !== 3'b011)
      $display("FAIL int_exec got %b exp 011", {fcsr_wr_en_o, csr_rvalid_o, csr_illegal_o}); else n_pass++;
    tick();
    fcsr_rd_error_i = 0; fpu_valid_i = 1; fpu_flags_i = 5'h1F; csr_op_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if ({err_o, fpu_ready_o, csr_op_ready_o, fcsr_wr_en_o, csr_rvalid_o} !== 5'b10000)
        $display("FAIL int_err%0d got %b exp 10000", i, {err_o, fpu_ready_o, csr_op_ready_o, fcsr_wr_en_o, csr_rvalid_o}); else n_pass++;
      tick();
    end
    n_chk++; if (fcsr_store !== 8'h96) $display("FAIL int_store got %h exp 96", fcsr_store); else n_pass++;
    do_reset(); #1;
    n_chk++; if ({err_o, fpu_ready_o, csr_op_ready_o, fcsr_wr_en_o, csr_rvalid_o} !== 5'b01100)
      $display("FAIL int_reset got %b exp 01100", {err_o, fpu_ready_o, csr_op_ready_o, fcsr_wr_en_o, csr_rvalid_o}); else n_pass++;
    // Error while a flush is due in IDLE.
    fpu_valid_i = 1; fpu_flags_i = 5'b00001; tick();
    fpu_valid_i = 0; fcsr_rd_error_i = 1; #1;
    n_chk++; if (fcsr_wr_en_o !== 1'b0) $display("FAIL int_idle_wr got %b exp 0", fcsr_wr_en_o); else n_pass++;
    tick();
    fcsr_rd_error_i = 0; #1;
    n_chk++; if (err_o !== 1'b1) $display("FAIL int_idle_err got %b exp 1", err_o); else n_pass++;
    do_reset();
    preload(8'h00);
  endtask

`ifdef IBEX_FCSR_FLAG_CNT_EN
  task automatic test_flag_cnt();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fpu_valid_i = 1; fpu_flags_i = (i < 3) ? 5'(1 << i) : 5'b0; tick();
    end
    quiet(); #1;
    n_chk++; if (flag_cnt_o !== 16'd3) $display("FAIL cnt_three got %0d exp 3", flag_cnt_o); else n_pass++;
    fpu_valid_i = 1; fpu_flags_i = 5'b00001;
    for (int i = 0; i < 65532; i++) tick();
    #1;
    n_chk++; if (flag_cnt_o !== 16'hFFFF) $display("FAIL cnt_max got %h exp ffff", flag_cnt_o); else n_pass++;
    tick(); tick(); tick();
    n_chk++; if (flag_cnt_o !== 16'hFFFF) $display("FAIL cnt_sat got %h exp ffff", flag_cnt_o); else n_pass++;
    quiet(); tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_flag_example();
    test_flag_random();
    test_csr_ops();
    test_back_to_back();
    test_reset_midop();
    test_integrity();
`ifdef IBEX_FCSR_FLAG_CNT_EN
    test_flag_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
